// File: rtl/dmem_pkg.sv
// Shared constants, vector FSM state type and address-to-bank mapping helpers
// for the banked data memory.
package dmem_pkg;

    localparam int DW_DEFAULT     = 32;
    localparam int AW_DEFAULT     = 32;
    localparam int DEPTH_DEFAULT  = 1024;
    localparam int NLANES_DEFAULT = 4;
    localparam int NBANKS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        RESP
    } vstate_e;

    // Low address bits select the bank so consecutive words spread across banks.
    function automatic int unsigned bankOf(input logic [63:0] addr, input int unsigned nbanks);
        return 32'(addr % 64'(nbanks));
    endfunction

    function automatic int unsigned rowOf(input logic [63:0] addr, input int unsigned nbanks,
                                          input int unsigned rows);
        return 32'((addr / 64'(nbanks)) % 64'(rows));
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One single-ported memory bank: combinational read, write on the rising edge.
// Contents are deliberately not reset.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int ROWS = DEPTH_DEFAULT / NBANKS_DEFAULT,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [RW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_banked.sv
// Banked data memory with an always-available scalar port and a vector port
// whose lanes are scheduled one per bank per cycle, scalar accesses taking priority.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int AW     = AW_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int NLANES = NLANES_DEFAULT,
    parameter int NBANKS = NBANKS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          we,
    input  logic [AW-1:0]                 a,
    input  logic [DW-1:0]                 wd,
    output logic [DW-1:0]                 rd,
    input  logic                          vreq_valid,
    output logic                          vreq_ready,
    input  logic                          vreq_we,
    input  logic [NLANES-1:0]             vreq_mask,
    input  logic [NLANES-1:0][AW-1:0]     va,
    input  logic [NLANES-1:0][DW-1:0]     wdv,
    output logic                          vrsp_valid,
    input  logic                          vrsp_ready,
    output logic [NLANES-1:0][DW-1:0]     rdv
);

    localparam int ROWS = DEPTH / NBANKS;
    localparam int BW   = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    vstate_e                      state_q, state_d;
    logic [NLANES-1:0]            pending_q, pending_d;
    logic [NLANES-1:0]            served;
    logic                         accept;
    logic                         vecWe_q;
    logic [NLANES-1:0][AW-1:0]    vecAddr_q;
    logic [NLANES-1:0][DW-1:0]    vecData_q;
    logic [NLANES-1:0][DW-1:0]    rdv_q, rdv_d;
    logic [DW-1:0]                rd_q;

    logic [BW-1:0]                scalarBank;
    logic [RW-1:0]                scalarRow;
    logic [BW-1:0]                laneBank [NLANES];
    logic [RW-1:0]                laneRow  [NLANES];

    logic [NBANKS-1:0]            bankWe;
    logic [RW-1:0]                bankAddr  [NBANKS];
    logic [DW-1:0]                bankWd    [NBANKS];
    logic [DW-1:0]                bankRdata [NBANKS];

    assign scalarBank = BW'(bankOf(64'(a), NBANKS));
    assign scalarRow  = RW'(rowOf(64'(a), NBANKS, ROWS));

    always_comb begin
        for (int l = 0; l < NLANES; l++) begin
            laneBank[l] = BW'(bankOf(64'(vecAddr_q[l]), NBANKS));
            laneRow[l]  = RW'(rowOf(64'(vecAddr_q[l]), NBANKS, ROWS));
        end
    end

    // Bank arbitration: scalar owns its bank outright; otherwise the lowest pending
    // lane mapped to the bank wins, which also orders same-address stores by lane.
    always_comb begin
        logic found;
        served = '0;
        for (int b = 0; b < NBANKS; b++) begin
            bankWe[b]   = 1'b0;
            bankAddr[b] = '0;
            bankWd[b]   = '0;
            found       = 1'b0;
            if (en && (scalarBank == BW'(b))) begin
                bankWe[b]   = we;
                bankAddr[b] = scalarRow;
                bankWd[b]   = wd;
            end else if ((state_q == SERVE) && !rst) begin
                for (int l = 0; l < NLANES; l++) begin
                    if (!found && pending_q[l] && (laneBank[l] == BW'(b))) begin
                        found       = 1'b1;
                        served[l]   = 1'b1;
                        bankWe[b]   = vecWe_q;
                        bankAddr[b] = laneRow[l];
                        bankWd[b]   = vecData_q[l];
                    end
                end
            end
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        dmem_bank #(
            .DW   (DW),
            .ROWS (ROWS),
            .RW   (RW)
        ) u_bank (
            .clk   (clk),
            .we    (bankWe[b]),
            .addr  (bankAddr[b]),
            .wdata (bankWd[b]),
            .rdata (bankRdata[b])
        );
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        accept     = 1'b0;
        vreq_ready = 1'b0;
        vrsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                vreq_ready = 1'b1;
                if (vreq_valid) begin
                    accept    = 1'b1;
                    pending_d = vreq_mask;
                    state_d   = (vreq_mask == '0) ? RESP : SERVE;
                end
            end
            SERVE: begin
                pending_d = pending_q & ~served;
                if (pending_d == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                vrsp_valid = 1'b1;
                if (vrsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdv_d = rdv_q;
        if (accept) begin
            rdv_d = '0;
        end else begin
            for (int l = 0; l < NLANES; l++) begin
                if (served[l] && !vecWe_q) begin
                    rdv_d[l] = bankRdata[laneBank[l]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rdv_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rdv_q     <= rdv_d;
            if (en && !we) begin
                rd_q <= bankRdata[scalarBank];
            end
        end
    end

    // Request payload is pure datapath; it is only meaningful while pending bits are set.
    always_ff @(posedge clk) begin
        if (accept) begin
            vecWe_q   <= vreq_we;
            vecAddr_q <= va;
            vecData_q <= wdv;
        end
    end

    assign rd  = rd_q;
    assign rdv = rdv_q;

endmodule
